// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the uCISC program loader.
// State encoding, frame field sizes, default load address and the
// checksum helpers used when the optional checksum byte is compiled in.
package loader_pkg;

  // Loader FSM state encoding.
  localparam logic [2:0] ST_LEN_HI  = 3'd0;
  localparam logic [2:0] ST_LEN_LO  = 3'd1;
  localparam logic [2:0] ST_DATA_HI = 3'd2;
  localparam logic [2:0] ST_DATA_LO = 3'd3;
  localparam logic [2:0] ST_CHECK   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;

  // Frame field sizes in bytes.
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned CHECKSUM_BYTES = 1;

  // Default first program memory address.
  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0000;

  // Running 8-bit checksum update.
  function automatic logic [7:0] checksum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

  // A frame is good when data bytes plus the checksum byte total 0 mod 256.
  function automatic logic checksum_ok(input logic [7:0] sum, input logic [7:0] check_byte);
    logic [7:0] total;
    total = checksum_add(sum, check_byte);
    return (total == 8'h00);
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: latches the high byte of each program word, packs
// {hi, lo} on the low byte, and issues a one-cycle write strobe with the
// address BASE_ADDR + words_loaded. The word counter (and thus the address)
// wraps modulo 2^ADDR_WIDTH. clear restarts a frame at BASE_ADDR.
module loader_word_assembler
  import loader_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR)
) (
  input  logic                  clock_input,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  hi_load,
  input  logic                  lo_load,
  input  logic [7:0]            rx_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [15:0]           mem_data_out,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

  localparam logic [ADDR_WIDTH-1:0] WORD_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [7:0]            hi_byte_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [15:0]           data_r;
  logic [ADDR_WIDTH-1:0] words_r;

  // Hold the high byte until its low byte arrives.
  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      hi_byte_r <= 8'h00;
    end else if (clear) begin
      hi_byte_r <= 8'h00;
    end else if (hi_load) begin
      hi_byte_r <= rx_data;
    end else begin
      hi_byte_r <= hi_byte_r;
    end
  end

  // Write strobe, address, packed data and word count, all updated on the low-byte edge.
  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      we_r    <= 1'b0;
      addr_r  <= BASE_ADDR;
      data_r  <= 16'h0000;
      words_r <= '0;
    end else if (clear) begin
      we_r    <= 1'b0;
      addr_r  <= BASE_ADDR;
      data_r  <= 16'h0000;
      words_r <= '0;
    end else if (lo_load) begin
      we_r    <= 1'b1;
      addr_r  <= BASE_ADDR + words_r;
      data_r  <= {hi_byte_r, rx_data};
      words_r <= words_r + WORD_ONE;
    end else begin
      we_r    <= 1'b0;
      addr_r  <= addr_r;
      data_r  <= data_r;
      words_r <= words_r;
    end
  end

  assign mem_write_enable = we_r;
  assign mem_address      = addr_r;
  assign mem_data_out     = data_r;
  assign words_loaded     = words_r;

endmodule

// File: rtl/program_loader.sv
// program_loader: boot-stage loader for the uCISC cpu. Receives a framed
// image (LEN_HI, LEN_LO, 2N data bytes high-first, optional checksum) over
// a valid/ready byte stream, writes 16-bit words into program memory and
// holds the cpu in reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing checksum
// byte, the CHECK state and the error output). Default build omits it.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR)
) (
  input  logic                  clock_input,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [15:0]           mem_data_out,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_CHECK;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_DONE;
`endif

  localparam logic [ADDR_WIDTH-1:0] WORD_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state_r;
  logic [2:0]            state_next_s;
  logic                  rx_ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  error_r;
  logic                  cpu_reset_r;
  logic                  rx_ready_next_s;
  logic                  ready_state_s;
  logic                  busy_next_s;
  logic                  done_next_s;
  logic                  error_next_s;
  logic                  cpu_reset_next_s;
  logic [7:0]            len_hi_r;
  logic [ADDR_WIDTH-1:0] n_r;
  logic [15:0]           len_word_s;
  logic                  len_zero_s;
  logic                  last_word_s;
  logic                  accept_s;
  logic                  hi_load_s;
  logic                  lo_load_s;
  logic [ADDR_WIDTH-1:0] words_s;

  // start wins over a byte in the same cycle, so the byte is never acknowledged.
  assign rx_ready   = rx_ready_r & ~start;
  assign accept_s   = rx_valid & rx_ready_r & ~start;
  assign hi_load_s  = accept_s & (state_r == ST_DATA_HI);
  assign lo_load_s  = accept_s & (state_r == ST_DATA_LO);
  assign len_word_s = {len_hi_r, rx_data};
  assign len_zero_s = (len_word_s == 16'h0000);
  assign last_word_s = ((words_s + WORD_ONE) == n_r);

  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign cpu_reset    = cpu_reset_r;
  assign words_loaded = words_s;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_r;
  logic       check_pass_s;

  assign check_pass_s = checksum_ok(sum_r, rx_data);

  // Running checksum over data bytes only.
  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      sum_r <= 8'h00;
    end else if (start) begin
      sum_r <= 8'h00;
    end else if (hi_load_s || lo_load_s) begin
      sum_r <= checksum_add(sum_r, rx_data);
    end else begin
      sum_r <= sum_r;
    end
  end
`endif

  // Frame length capture.
  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      len_hi_r <= 8'h00;
      n_r      <= '0;
    end else if (start) begin
      len_hi_r <= 8'h00;
      n_r      <= '0;
    end else if (accept_s && (state_r == ST_LEN_HI)) begin
      len_hi_r <= rx_data;
      n_r      <= n_r;
    end else if (accept_s && (state_r == ST_LEN_LO)) begin
      len_hi_r <= len_hi_r;
      n_r      <= ADDR_WIDTH'(len_word_s);
    end else begin
      len_hi_r <= len_hi_r;
      n_r      <= n_r;
    end
  end

  // State and registered handshake/status outputs.
  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      state_r     <= ST_LEN_HI;
      rx_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      cpu_reset_r <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      rx_ready_r  <= rx_ready_next_s;
      busy_r      <= busy_next_s;
      done_r      <= done_next_s;
      error_r     <= error_next_s;
      cpu_reset_r <= cpu_reset_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    if (start) begin
      state_next_s = ST_LEN_HI;
    end else if (accept_s) begin
      case (state_r)
        ST_LEN_HI:  state_next_s = ST_LEN_LO;
        ST_LEN_LO:  state_next_s = len_zero_s ? ST_AFTER_DATA : ST_DATA_HI;
        ST_DATA_HI: state_next_s = ST_DATA_LO;
        ST_DATA_LO: state_next_s = last_word_s ? ST_AFTER_DATA : ST_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK:   state_next_s = check_pass_s ? ST_DONE : ST_ERROR;
`endif
        default:    state_next_s = state_r;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Output decode from the upcoming state; cpu_reset lags DONE by one edge.
  always_comb begin
    ready_state_s = 1'b0;
    busy_next_s   = 1'b0;
    done_next_s   = 1'b0;
    error_next_s  = 1'b0;
    case (state_next_s)
      ST_LEN_HI: begin
        ready_state_s = 1'b1;
      end
      ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: begin
        ready_state_s = 1'b1;
        busy_next_s   = 1'b1;
      end
      ST_DONE: begin
        done_next_s = 1'b1;
      end
      ST_ERROR: begin
`ifdef LOADER_CHECKSUM_EN
        error_next_s = 1'b1;
`else
        error_next_s = 1'b0;
`endif
      end
      default: begin
        ready_state_s = 1'b0;
      end
    endcase
    // No byte is taken while the write strobe for the previous word is high.
    rx_ready_next_s  = ready_state_s & ~lo_load_s;
    cpu_reset_next_s = start | (state_r != ST_DONE);
  end

  loader_word_assembler #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_word_assembler (
    .clock_input      (clock_input),
    .reset            (reset),
    .clear            (start),
    .hi_load          (hi_load_s),
    .lo_load          (lo_load_s),
    .rx_data          (rx_data),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_data_out     (mem_data_out),
    .words_loaded     (words_s)
  );

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader. Two instances share
// the stimulus: one at the default base address, one at 16'hFFFF to exercise
// address wrap. Expected writes are queued when frames are issued and a
// monitor pops and compares them on every write strobe.
module tb_program_loader;

  logic        clock_input = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        rx_ready_a, mem_write_enable_a, cpu_reset_a, busy_a, done_a, error_a;
  logic [15:0] mem_address_a, mem_data_out_a, words_loaded_a;
  logic        rx_ready_b, mem_write_enable_b, cpu_reset_b, busy_b, done_b, error_b;
  logic [15:0] mem_address_b, mem_data_out_b, words_loaded_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] off;
    logic [15:0] data;
  } exp_t;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] frame_q[$];

  always #5 clock_input = ~clock_input;

  program_loader #(.ADDR_WIDTH(16), .BASE_ADDR(16'h0000)) dut_a (
    .clock_input(clock_input), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_a),
    .mem_write_enable(mem_write_enable_a), .mem_address(mem_address_a),
    .mem_data_out(mem_data_out_a), .cpu_reset(cpu_reset_a), .busy(busy_a),
    .done(done_a), .error(error_a), .words_loaded(words_loaded_a)
  );

  program_loader #(.ADDR_WIDTH(16), .BASE_ADDR(16'hFFFF)) dut_b (
    .clock_input(clock_input), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_b),
    .mem_write_enable(mem_write_enable_b), .mem_address(mem_address_b),
    .mem_data_out(mem_data_out_b), .cpu_reset(cpu_reset_b), .busy(busy_b),
    .done(done_b), .error(error_b), .words_loaded(words_loaded_b)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  task automatic push_word(input logic [15:0] off, input logic [15:0] data);
    exp_t e;
    e.off  = off;
    e.data = data;
    q_a.push_back(e);
    q_b.push_back(e);
  endtask

  // Pops an expected write for each strobe seen on either instance.
  task automatic monitor();
    exp_t        e;
    logic [15:0] ea;
    forever begin
      @(negedge clock_input);
      if (mem_write_enable_a) begin
        chk("write_expected_a", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          chk("addr_a", mem_address_a, e.off);
          chk("data_a", mem_data_out_a, e.data);
          chk("words_at_write_a", words_loaded_a, e.off + 16'd1);
        end
      end
      if (mem_write_enable_b) begin
        chk("write_expected_b", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          e  = q_b.pop_front();
          ea = 16'hFFFF + e.off;
          chk("addr_b", mem_address_b, ea);
          chk("data_b", mem_data_out_b, e.data);
        end
      end
    end
  endtask

  // Present one byte after an idle gap; return once it has been accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic accepted;
    logic ready_seen;
    rx_valid = 1'b0;
    rx_data  = 8'h5A;
    repeat (gap) begin
      @(posedge clock_input);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock_input);
      ready_seen = rx_ready_a;
      @(posedge clock_input);
      #1;
      accepted = ready_seen;
    end
    if (!accepted) chk("byte_accept_timeout", 32'd0, 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame_q[i]) send_byte(frame_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  // Bounded wait for done or error.
  task automatic wait_end(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock_input);
      seen = done_a | error_a;
    end
    if (!seen) chk(name, 32'd0, 32'd1);
  endtask

  // Start pulse with a byte offered at the same time; the byte must be refused.
  task automatic pulse_start();
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    @(negedge clock_input);
    chk("ready_during_start", rx_ready_a, 32'd0);
    @(posedge clock_input);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clock_input);
    chk("start_busy", busy_a, 32'd0);
    chk("start_done", done_a, 32'd0);
    chk("start_error", error_a, 32'd0);
    chk("start_words", words_loaded_a, 32'd0);
    chk("start_cpu_reset", cpu_reset_a, 32'd1);
    chk("start_ready", rx_ready_a, 32'd1);
    @(posedge clock_input);
    #1;
  endtask

  initial begin
    fork
      monitor();
    join_none

    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clock_input);
    chk("rst_ready", rx_ready_a, 32'd0);
    chk("rst_cpu_reset", cpu_reset_a, 32'd1);
    chk("rst_we", mem_write_enable_a, 32'd0);
    chk("rst_addr_a", mem_address_a, 32'h0000);
    chk("rst_addr_b", mem_address_b, 32'hFFFF);
    chk("rst_data", mem_data_out_a, 32'd0);
    chk("rst_words", words_loaded_a, 32'd0);
    chk("rst_busy", busy_a, 32'd0);
    chk("rst_done", done_a, 32'd0);
    chk("rst_error", error_a, 32'd0);
    @(posedge clock_input);
    #1;
    reset = 1'b0;

    // Three-word image, sent back-to-back.
    frame_q = '{8'h00, 8'h03, 8'h80, 8'h01, 8'h07, 8'hFF, 8'h41, 8'h23};
`ifdef LOADER_CHECKSUM_EN
    frame_q.push_back(8'h15);
`endif
    push_word(16'd0, 16'h8001);
    push_word(16'd1, 16'h07FF);
    push_word(16'd2, 16'h4123);
    send_frame(0);
    wait_end("t1_end_timeout");
    chk("t1_done", done_a, 32'd1);
    chk("t1_error", error_a, 32'd0);
    chk("t1_words", words_loaded_a, 32'd3);
    chk("t1_busy", busy_a, 32'd0);
    chk("t1_ready", rx_ready_a, 32'd0);
    chk("t1_cpu_reset_at_done", cpu_reset_a, 32'd1);
    @(negedge clock_input);
    chk("t1_cpu_reset_after", cpu_reset_a, 32'd0);
    chk("t1_cpu_reset_after_b", cpu_reset_b, 32'd0);
    chk("t1_done_b", done_b, 32'd1);

    // Bytes offered in DONE are never accepted.
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    repeat (4) begin
      @(negedge clock_input);
      chk("done_inert_ready", rx_ready_a, 32'd0);
    end
    rx_valid = 1'b0;
    chk("done_inert_words", words_loaded_a, 32'd3);
    chk("done_inert_done", done_a, 32'd1);
    @(posedge clock_input);
    #1;

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum rejects the frame; the words are still written.
    pulse_start();
    frame_q = '{8'h00, 8'h03, 8'h80, 8'h01, 8'h07, 8'hFF, 8'h41, 8'h23, 8'h16};
    push_word(16'd0, 16'h8001);
    push_word(16'd1, 16'h07FF);
    push_word(16'd2, 16'h4123);
    send_frame(0);
    wait_end("t2_end_timeout");
    chk("t2_error", error_a, 32'd1);
    chk("t2_done", done_a, 32'd0);
    @(negedge clock_input);
    chk("t2_cpu_reset", cpu_reset_a, 32'd1);
    chk("t2_ready", rx_ready_a, 32'd0);
    pulse_start();
    frame_q = '{8'h00, 8'h03, 8'h80, 8'h01, 8'h07, 8'hFF, 8'h41, 8'h23, 8'h15};
    push_word(16'd0, 16'h8001);
    push_word(16'd1, 16'h07FF);
    push_word(16'd2, 16'h4123);
    send_frame(0);
    wait_end("t2b_end_timeout");
    chk("t2b_done", done_a, 32'd1);
    chk("t2b_error", error_a, 32'd0);
`endif

    // Empty image: no writes, straight to DONE.
    pulse_start();
    frame_q = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    frame_q.push_back(8'h00);
`endif
    send_frame(0);
    wait_end("t3_end_timeout");
    chk("t3_done", done_a, 32'd1);
    chk("t3_words", words_loaded_a, 32'd0);
    @(negedge clock_input);
    chk("t3_cpu_reset", cpu_reset_a, 32'd0);

    // Partial frame with gaps, aborted by start after three data bytes.
    pulse_start();
    push_word(16'd0, 16'hABCD);
    send_byte(8'h00, int'($urandom_range(0, 3)));
    send_byte(8'h02, int'($urandom_range(0, 3)));
    send_byte(8'hAB, int'($urandom_range(0, 3)));
    send_byte(8'hCD, int'($urandom_range(0, 3)));
    send_byte(8'h12, int'($urandom_range(0, 3)));
    repeat (2) begin
      @(posedge clock_input);
      #1;
    end
    chk("t4_busy_mid", busy_a, 32'd1);
    chk("t4_words_mid", words_loaded_a, 32'd1);
    pulse_start();
    // Full reload; instance b writes FFFF then wraps to 0000.
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef LOADER_CHECKSUM_EN
    frame_q.push_back(8'hEC);
`endif
    push_word(16'd0, 16'h1234);
    push_word(16'd1, 16'h5678);
    send_frame(3);
    wait_end("t4_end_timeout");
    chk("t4_done", done_a, 32'd1);
    chk("t4_words", words_loaded_a, 32'd2);
    chk("t4_done_b", done_b, 32'd1);

    // Asynchronous reset while waiting for a low data byte.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    rx_data  = 8'hBB;
    rx_valid = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("t5_we", mem_write_enable_a, 32'd0);
    chk("t5_addr_a", mem_address_a, 32'h0000);
    chk("t5_addr_b", mem_address_b, 32'hFFFF);
    chk("t5_data", mem_data_out_a, 32'd0);
    chk("t5_words", words_loaded_a, 32'd0);
    chk("t5_busy", busy_a, 32'd0);
    chk("t5_cpu_reset", cpu_reset_a, 32'd1);
    chk("t5_ready", rx_ready_a, 32'd0);
    chk("t5_done", done_a, 32'd0);
    repeat (2) @(posedge clock_input);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(negedge clock_input);
    chk("t5_words_after", words_loaded_a, 32'd0);

    chk("pending_writes_a", 32'(q_a.size()), 32'd0);
    chk("pending_writes_b", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream boot stage for the uCISC cpu.
- Accepts a framed program image as a byte stream over a valid/ready handshake.
- Assembles big-endian 16-bit words and writes them into the cpu's program memory starting at BASE_ADDR.
- Holds the cpu in reset until a complete, checked image has been loaded, then releases it so execution starts at pc 0x0000.

Parameters:
- BASE_ADDR, 16'h0000, first memory address written.
- ADDR_WIDTH, 16, width of mem_address and of the word counters.

Ports:
- clock_input  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; re-arms the loader from any state.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte this cycle.
- mem_write_enable  out  1  one-cycle memory write strobe.
- mem_address  out  ADDR_WIDTH  write address.
- mem_data_out  out  16  write data.
- cpu_reset  out  1  drives the cpu reset input; high while not loaded.
- busy  out  1  a frame is in progress.
- done  out  1  image loaded; cpu is running.
- error  out  1  frame rejected.
- words_loaded  out  ADDR_WIDTH  number of words written in the current frame.

Behaviour:
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then 2N data bytes (high byte first), then one checksum byte only when LOADER_CHECKSUM_EN is defined.
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- Reset (asynchronous): state=LEN_HI; cpu_reset=1; rx_ready=0 in the reset cycle; mem_write_enable=0; mem_address=BASE_ADDR; mem_data_out=0; words_loaded=0; busy=0; done=0; error=0.
- Byte accepted on a rising edge when rx_valid && rx_ready.
- rx_ready is registered. It is 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 in DONE and ERROR.
- busy=1 from the first accepted LEN_HI byte until DONE or ERROR.
- Transitions:
  - LEN_HI -> LEN_LO on accept.
  - LEN_LO -> DATA_HI if N!=0.
  - LEN_LO with N==0 -> CHECK if the feature is enabled, else DONE.
  - DATA_HI -> DATA_LO on accept; the high byte is latched.
  - DATA_LO -> DATA_HI, or -> CHECK/DONE after word N.
- Memory write timing:
  - Write latency is exactly 1 cycle.
  - In the cycle after a DATA_LO accept: mem_write_enable=1 for one cycle, with mem_address = BASE_ADDR + words_loaded(old) and mem_data_out = {hi, lo}.
  - words_loaded increments on the same edge that raises the strobe.
- mem_address wraps modulo 2^ADDR_WIDTH; a wrap is not an error.
- No byte is accepted while the write strobe is high: rx_ready drops in the strobe cycle if the next byte would arrive back-to-back. Maximum throughput is therefore 2 bytes per 3 cycles.
- DONE: cpu_reset=0 (registered, deasserted the edge after DONE is entered); done=1; busy=0. The loader is then inert.
- ERROR: cpu_reset stays 1; error=1; the loader waits for start.
- start, any state: next state LEN_HI; counters cleared; done=0, error=0; cpu_reset=1.
  - start has priority over a simultaneous byte accept; that byte is dropped (rx_ready is 0 that cycle).
  - start mid-frame discards the partial frame. Words already written stay in memory.
- rx_data is ignored while rx_valid=0. Bytes arriving in DONE/ERROR are never accepted.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit running sum covers data bytes only (not the length bytes).
  - In CHECK, the accepted byte is added; a total of 0 mod 256 goes to DONE, anything else to ERROR.
- Disabled:
  - No CHECK state and no accumulator logic.
  - The last DATA_LO byte (or N==0) goes directly to DONE.
  - error is tied to 0.

Decomposition:
- Shared package loader_pkg holds:
  - the state encoding localparams;
  - frame field constants (LEN byte count 2, CHECKSUM_BYTES 1);
  - the default BASE_ADDR.
- One natural sub-module: loader_word_assembler. It covers byte latching, the {hi, lo} pack, the write-strobe pulse and the address/words counter.
- The FSM and handshake stay in program_loader.

Test Plan:
- Feature on; bytes 00 03 80 01 07 FF 41 23 15 sent back-to-back:
  - three strobes: mem[0]=8001, mem[1]=07FF, mem[2]=4123;
  - words_loaded=3, done=1;
  - cpu_reset falls one cycle after DONE.
- Same frame with checksum byte 16 -> error=1, cpu_reset stays 1. Then start, then the correct frame -> done=1.
- Frame 00 00 (plus checksum 00 when enabled) -> no mem_write_enable, done=1, words_loaded=0.
- Random rx_valid gaps and a start pulse after 3 data bytes:
  - only mem[0] is written;
  - the loader returns to LEN_HI;
  - a full reload succeeds.
- BASE_ADDR=16'hFFFF, N=2 -> writes at FFFF then 0000 (wrap), done=1.
- Assert reset mid-DATA_LO -> all outputs at reset values immediately (asynchronously), cpu_reset=1, no spurious strobe.
